// File: rtl/mf_pkg.sv
// Shared constants, FSM state type and rounding-mean helper for the salt-noise mean filter.
package mf_pkg;

    localparam int unsigned PIX_W = 8;
    localparam logic [PIX_W-1:0] SALT_VAL = 8'hFF;
    localparam logic [PIX_W-1:0] PEPPER_VAL = 8'h00;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } mf_state_e;

    // Round-half-up mean; the 9-bit sum cannot overflow (255 + 255 + 1 = 511).
    function automatic logic [PIX_W-1:0] mf_mean(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
        logic [PIX_W:0] s;
        s = {1'b0, a} + {1'b0, b} + {{PIX_W{1'b0}}, 1'b1};
        return s[PIX_W:1];
    endfunction

endpackage

// File: rtl/mean_filter_ctrl_if.sv
// Pixel stream handshake and status bundle between source, filter controller and sink.
interface mean_filter_ctrl_if
    import mf_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic             in_sof;
    logic [PIX_W-1:0] in_pixel;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_pixel;
    logic             out_eol;
    logic             out_eof;
    logic             out_fixed;
    logic [CNT_W-1:0] salt_cnt;
    logic             frame_done;

    modport slave (
        input  in_valid, in_sof, in_pixel, out_ready,
        output in_ready, out_valid, out_pixel, out_eol, out_eof, out_fixed, salt_cnt, frame_done
    );

    modport master (
        output in_valid, in_sof, in_pixel, out_ready,
        input  in_ready, out_valid, out_pixel, out_eol, out_eof, out_fixed, salt_cnt, frame_done
    );

endinterface

// File: rtl/mf_line_buf.sv
// One-row buffer of filtered pixels: combinational read, synchronous write, no reset needed.
module mf_line_buf
    import mf_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [PIX_W-1:0] o_rd_data,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [PIX_W-1:0] i_wr_data
);

    logic [PIX_W-1:0] r_mem [WIDTH];

    assign o_rd_data = r_mem[i_rd_addr];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

endmodule

// File: rtl/mean_filter_ctrl.sv
// Salt-noise mean filter controller: raster scan, noisy pixels replaced from filtered left/up.
// Optional MF_PEPPER_EN: 8'h00 is treated as noise as well as 8'hFF.
module mean_filter_ctrl
    import mf_pkg::*;
#(
    parameter int unsigned      WIDTH  = 4,
    parameter int unsigned      HEIGHT = 4,
    parameter logic [PIX_W-1:0] PAD    = 8'd128,
    parameter int unsigned      CNT_W  = 16
) (
    input logic clk,
    input logic rst,
    mean_filter_ctrl_if.slave bus
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned RW = $clog2(HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    mf_state_e        r_state;
    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [PIX_W-1:0] r_left;
    logic             r_out_valid;
    logic [PIX_W-1:0] r_out_pixel;
    logic             r_out_eol;
    logic             r_out_eof;
    logic             r_out_fixed;
    logic [CNT_W-1:0] r_salt_cnt;
    logic             r_frame_done;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_take;
    logic [CW-1:0]    w_col;
    logic [RW-1:0]    w_row;
    logic             w_noise;
    logic [PIX_W-1:0] w_up;
    logic [PIX_W-1:0] w_repl;
    logic [PIX_W-1:0] w_filt;
    logic             w_eol;
    logic             w_eof;

    assign w_in_ready = ~r_out_valid | bus.out_ready;
    assign w_accept   = bus.in_valid & w_in_ready;
    // In IDLE only sof pixels are processed; everything else is accepted and dropped.
    assign w_take     = w_accept & (bus.in_sof | (r_state == ACTIVE));
    assign w_col      = bus.in_sof ? '0 : r_col;
    assign w_row      = bus.in_sof ? '0 : r_row;
    assign w_eol      = (w_col == COL_LAST);
    assign w_eof      = w_eol & (w_row == ROW_LAST);

`ifdef MF_PEPPER_EN
    assign w_noise = (bus.in_pixel == SALT_VAL) | (bus.in_pixel == PEPPER_VAL);
`else
    assign w_noise = (bus.in_pixel == SALT_VAL);
`endif

    mf_line_buf #(
        .WIDTH (WIDTH),
        .AW    (CW)
    ) u_line_buf (
        .clk       (clk),
        .i_rd_addr (w_col),
        .o_rd_data (w_up),
        .i_wr_en   (w_take),
        .i_wr_addr (w_col),
        .i_wr_data (w_filt)
    );

    always_comb begin
        w_repl = PAD;
        if (w_row == '0 && w_col == '0) begin
            w_repl = PAD;
        end else if (w_row == '0) begin
            w_repl = r_left;
        end else if (w_col == '0) begin
            w_repl = w_up;
        end else begin
            w_repl = mf_mean(r_left, w_up);
        end
    end

    assign w_filt = w_noise ? w_repl : bus.in_pixel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_left       <= '0;
            r_out_valid  <= 1'b0;
            r_out_pixel  <= '0;
            r_out_eol    <= 1'b0;
            r_out_eof    <= 1'b0;
            r_out_fixed  <= 1'b0;
            r_salt_cnt   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= r_out_valid & bus.out_ready & r_out_eof;
            if (w_take) begin
                r_out_valid <= 1'b1;
                r_out_pixel <= w_filt;
                r_out_eol   <= w_eol;
                r_out_eof   <= w_eof;
                r_out_fixed <= w_noise;
                r_left      <= w_filt;
                if (w_eof) begin
                    r_state <= IDLE;
                    r_col   <= '0;
                    r_row   <= '0;
                end else if (w_eol) begin
                    r_state <= ACTIVE;
                    r_col   <= '0;
                    r_row   <= w_row + 1'b1;
                end else begin
                    r_state <= ACTIVE;
                    r_col   <= w_col + 1'b1;
                    r_row   <= w_row;
                end
                if (bus.in_sof) begin
                    r_salt_cnt <= {{(CNT_W - 1){1'b0}}, w_noise};
                end else if (w_noise && !(&r_salt_cnt)) begin
                    r_salt_cnt <= r_salt_cnt + 1'b1;
                end
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_pixel  = r_out_pixel;
    assign bus.out_eol    = r_out_eol;
    assign bus.out_eof    = r_out_eof;
    assign bus.out_fixed  = r_out_fixed;
    assign bus.salt_cnt   = r_salt_cnt;
    assign bus.frame_done = r_frame_done;

endmodule
